// File: rtl/mac_if.sv
// Operand/result stream bundle for mac_pipe_n: operand pairs in, one
// accumulated result per packet out, each with a valid/ready handshake.
interface mac_if #(
  parameter int N     = 8,
  parameter int ACC_W = 2*N+8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [N-1:0]     a;
  logic signed [N-1:0]     b;
  logic                    last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] acc_out;
  logic                    ovf;

  modport master (
    output in_valid, a, b, last, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, a, b, last, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/mac_pipe_n.sv
// Three-stage pipelined signed multiply-accumulate: operand register, product
// register, accumulate/emit. One result per packet, optional saturation.
module mac_pipe_n #(
  parameter int N     = 8,
  parameter int ACC_W = 2*N+8,
  parameter int SAT   = 0
) (
  input logic  clk,
  input logic  rst,
  mac_if.slave bus
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic                    stall, accept;
  logic [1:0]              vld_q, last_q;
  logic signed [N-1:0]     a_q, b_q;
  logic signed [2*N-1:0]   mul;
  logic signed [ACC_W-1:0] prod_q, acc_q, acc_out_q, sum_raw, sum_d;
  logic                    ovf_run_q, ovf_out_q, out_valid_q, ovf_add, pkt_ovf;

  // Whole pipeline freezes while a finished result waits on the consumer.
  assign stall         = out_valid_q & ~bus.out_ready;
  assign accept        = bus.in_valid & ~stall;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.ovf       = ovf_out_q;

  // Widen before multiplying so -2^(N-1) * -2^(N-1) stays exact.
  assign mul = (2*N)'(a_q) * (2*N)'(b_q);

  always_comb begin
    sum_raw = acc_q + prod_q;
    ovf_add = (acc_q[ACC_W-1] == prod_q[ACC_W-1]) &&
              (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
    sum_d   = sum_raw;
    if (SAT != 0 && ovf_add)
      sum_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    pkt_ovf = ovf_run_q | ovf_add;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      last_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      ovf_run_q   <= 1'b0;
      acc_out_q   <= '0;
      ovf_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      vld_q  <= {vld_q[0], accept};
      last_q <= {last_q[0], bus.last};
      if (accept) begin
        a_q <= bus.a;
        b_q <= bus.b;
      end
      prod_q      <= ACC_W'(mul);
      out_valid_q <= vld_q[1] & last_q[1];
      // Clearing acc on the last pair makes the next packet start from zero.
      if (vld_q[1]) begin
        if (last_q[1]) begin
          acc_out_q <= sum_d;
          ovf_out_q <= pkt_ovf;
          acc_q     <= '0;
          ovf_run_q <= 1'b0;
        end else begin
          acc_q     <= sum_d;
          ovf_run_q <= pkt_ovf;
        end
      end
    end
  end
endmodule
